// File: rtl/cpu_if_bridge.sv
// CPU-side bridge for the 16-bit CPU interface tile pins: OUT register, filtered IN with RX FIFO, IRQ.
// Optional: define CPU_IF_BRIDGE_TIMESTAMP_EN to tag each RX entry with a 15-bit push-time counter.
module cpu_if_bridge #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned RX_DEPTH      = 4,
  parameter logic [15:0] OUT_RESET     = 16'h0000
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [15:0] fab_to,
  input  logic [15:0] fab_from,
  output logic        irq
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_IDLE, S_RESP} bus_state_t;

  bus_state_t   r_state;
  logic         r_ready;
  logic [31:0]  r_rdata;
  logic [15:0]  r_out;
  logic         r_irq;
  logic         r_irq_en;
  logic         r_ovf;

  logic [15:0]  r_smp;
  logic [15:0]  r_cand;
  logic [15:0]  r_last;
  logic [7:0]   r_cnt;

  logic [15:0]  r_mem [RX_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;

`ifdef CPU_IF_BRIDGE_TIMESTAMP_EN
  logic [14:0]  r_ts;
  logic [14:0]  r_ts_mem [RX_DEPTH];
`endif

  logic         w_accept;
  logic         w_wr;
  logic         w_nonempty;
  logic         w_full;
  logic         w_push;
  logic         w_pop;
  logic         w_do_push;
  logic [4:0]   w_count5;
  logic [14:0]  w_head_ts;
  logic [31:0]  w_rd_data;
  logic         w_unused;

  assign w_unused   = ^bus_wdata[31:16];

  assign w_accept   = bus_valid && (r_state == S_IDLE);
  assign w_wr       = w_accept && bus_we;
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(RX_DEPTH));
  assign w_count5   = 5'(r_count);

  // Push fires only on the increment that reaches the threshold, and only for a new value.
  assign w_push     = (r_smp == r_cand) && (r_cnt < 8'(STABLE_CYCLES)) &&
                      ((r_cnt + 8'd1) == 8'(STABLE_CYCLES)) && (r_cand != r_last);
  assign w_pop      = w_accept && !bus_we && (bus_addr == 2'd2) && w_nonempty;
  assign w_do_push  = w_push && (!w_full || w_pop);

`ifdef CPU_IF_BRIDGE_TIMESTAMP_EN
  assign w_head_ts  = r_ts_mem[r_rp];
`else
  assign w_head_ts  = '0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (bus_addr)
      2'd0: w_rd_data = {16'h0000, r_out};
      2'd1: w_rd_data = {16'h0000, r_smp};
      2'd2: w_rd_data = w_nonempty ? {w_head_ts, 1'b1, r_mem[r_rp]} : '0;
      2'd3: w_rd_data = {23'h0, w_count5, r_irq_en, r_ovf, w_full, w_nonempty};
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_out    <= OUT_RESET;
      r_irq    <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_smp    <= '0;
      r_cand   <= '0;
      r_last   <= '0;
      r_cnt    <= 8'(STABLE_CYCLES);
      r_wp     <= '0;
      r_rp     <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_rdata <= bus_we ? '0 : w_rd_data;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_rdata <= '0;
        end
      endcase

      if (w_wr && (bus_addr == 2'd0)) r_out <= bus_wdata[15:0];
      if (w_wr && (bus_addr == 2'd3)) begin
        r_irq_en <= bus_wdata[3];
        if (bus_wdata[2]) r_ovf <= 1'b0;
      end
      // A fresh overflow on the same edge as a W1C wins.
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;

      r_smp <= fab_from;
      if (r_smp != r_cand) begin
        r_cand <= r_smp;
        r_cnt  <= '0;
      end else if (r_cnt < 8'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_push) r_last <= r_cand;

      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_irq <= r_irq_en && (w_nonempty || r_ovf);
    end
  end

  always_ff @(posedge UserCLK) begin
    if (w_do_push) r_mem[r_wp] <= r_cand;
  end

`ifdef CPU_IF_BRIDGE_TIMESTAMP_EN
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) r_ts <= '0;
    else         r_ts <= r_ts + 15'd1;
  end

  always_ff @(posedge UserCLK) begin
    if (w_do_push) r_ts_mem[r_wp] <= r_ts;
  end
`endif

  assign bus_rdata = r_rdata;
  assign bus_ready = r_ready;
  assign fab_to    = r_out;
  assign irq       = r_irq;

endmodule
